// File: rtl/mem_arbiter.sv
// Purpose: time-shares one single-port SRAM between fetch (F) and data (M) requesters.
// Latency: grant and SRAM strobe combinational; read data returned LAT+1 cycles after grant.
// Backpressure: requesters hold req until gnt; no grants while a read is in flight.
module mem_arbiter #(
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        m_req,
    input  logic [15:0] m_addr,
    input  logic [3:0]  m_w_en,
    input  logic [31:0] m_wdata,
    output logic        m_gnt,
    output logic        m_rvalid,
    output logic [31:0] m_rdata,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    output logic [3:0]  mem_w_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LAT_C    = 3'(LAT);
    localparam logic [2:0] STARVE_C = 3'(STARVE_MAX);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner_m;
    logic [2:0]  r_lat_cnt;
    logic [2:0]  r_starve_cnt;
    logic [31:0] r_f_rdata;
    logic [31:0] r_m_rdata;
    logic        r_f_rvalid;
    logic        r_m_rvalid;

    logic        w_idle;
    logic        w_f_force;
    logic        w_m_win;
    logic        w_f_win;
    logic        w_rd_grant;
    logic        w_done;

    // Winner selection: data beats fetch unless fetch has lost STARVE_MAX times in a row.
    always_comb begin
        w_idle     = (r_state == S_IDLE);
        w_f_force  = f_req && (r_starve_cnt == STARVE_C);
        w_m_win    = w_idle && m_req && !w_f_force;
        w_f_win    = w_idle && f_req && !w_m_win;
        w_rd_grant = w_f_win || (w_m_win && (m_w_en == 4'b0000));
        w_done     = (r_state == S_BUSY) && (r_lat_cnt == LAT_C);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and SRAM-side outputs; writes never leave IDLE.
    always_comb begin
        w_state_nxt = r_state;
        f_gnt       = w_f_win;
        m_gnt       = w_m_win;
        mem_en      = w_f_win || w_m_win;
        mem_addr    = 16'h0000;
        mem_w_en    = 4'b0000;
        mem_wdata   = 32'h0000_0000;
        if (w_m_win) begin
            mem_addr  = m_addr;
            mem_w_en  = m_w_en;
            mem_wdata = m_wdata;
        end else if (w_f_win) begin
            mem_addr  = f_addr;
        end
        case (r_state)
            S_IDLE: if (w_rd_grant) w_state_nxt = S_BUSY;
            S_BUSY: if (w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latency counter and owner of the in-flight read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_cnt <= 3'd0;
            r_owner_m <= 1'b0;
        end else if (w_idle) begin
            if (w_rd_grant) begin
                r_lat_cnt <= 3'd1;
                r_owner_m <= w_m_win;
            end
        end else if (w_done) begin
            r_lat_cnt <= 3'd0;
        end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
        end
    end

    // Fetch starvation counter: counts M grants that beat a waiting fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 3'd0;
        end else if (!f_req || w_f_win) begin
            r_starve_cnt <= 3'd0;
        end else if (w_m_win && (r_starve_cnt != STARVE_C)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end

    // Capture read data for the owner on the last latency cycle; rvalid pulses one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_f_rdata  <= 32'h0000_0000;
            r_m_rdata  <= 32'h0000_0000;
            r_f_rvalid <= 1'b0;
            r_m_rvalid <= 1'b0;
        end else begin
            r_f_rvalid <= 1'b0;
            r_m_rvalid <= 1'b0;
            if (w_done) begin
                if (r_owner_m) begin
                    r_m_rdata  <= mem_rdata;
                    r_m_rvalid <= 1'b1;
                end else begin
                    r_f_rdata  <= mem_rdata;
                    r_f_rvalid <= 1'b1;
                end
            end
        end
    end

    assign f_rdata  = r_f_rdata;
    assign m_rdata  = r_m_rdata;
    assign f_rvalid = r_f_rvalid;
    assign m_rvalid = r_m_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed check of mem_arbiter at LAT=1 (inst 0), LAT=4 (inst 1), LAT=3 (inst 2).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: each instance has its own behavioural SRAM model with registered read address.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [3];
    logic        f_req     [3];
    logic [15:0] f_addr    [3];
    logic        f_gnt     [3];
    logic        f_rvalid  [3];
    logic [31:0] f_rdata   [3];
    logic        m_req     [3];
    logic [15:0] m_addr    [3];
    logic [3:0]  m_w_en    [3];
    logic [31:0] m_wdata   [3];
    logic        m_gnt     [3];
    logic        m_rvalid  [3];
    logic [31:0] m_rdata   [3];
    logic        mem_en    [3];
    logic [15:0] mem_addr  [3];
    logic [3:0]  mem_w_en  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [31:0] dflt(input logic [15:0] a);
        case (a)
            16'h0010: return 32'hDEAD_BEEF;
            16'h0020: return 32'h0BAD_F00D;
            default:  return {16'hA5A5, a};
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [15:0]  rd_addr;
        logic [31:0]  mem [256];
        logic [255:0] wr = '0;
        logic [7:0]   w_idx;
        assign w_idx = mem_addr[g][9:2];

        mem_arbiter #(.LAT(g == 0 ? 1 : (g == 1 ? 4 : 3)), .STARVE_MAX(3)) u_dut (
            .clk(clk), .rst(rst[g]),
            .f_req(f_req[g]), .f_addr(f_addr[g]), .f_gnt(f_gnt[g]),
            .f_rvalid(f_rvalid[g]), .f_rdata(f_rdata[g]),
            .m_req(m_req[g]), .m_addr(m_addr[g]), .m_w_en(m_w_en[g]), .m_wdata(m_wdata[g]),
            .m_gnt(m_gnt[g]), .m_rvalid(m_rvalid[g]), .m_rdata(m_rdata[g]),
            .mem_en(mem_en[g]), .mem_addr(mem_addr[g]), .mem_w_en(mem_w_en[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        always @(posedge clk) begin
            if (mem_en[g]) begin
                if (mem_w_en[g] != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_w_en[g][b]) mem[w_idx][8*b +: 8] <= mem_wdata[g][8*b +: 8];
                    wr[w_idx] <= 1'b1;
                end else begin
                    rd_addr <= mem_addr[g];
                end
            end
        end

        assign mem_rdata[g] = wr[rd_addr[9:2]] ? mem[rd_addr[9:2]] : dflt(rd_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // All control outputs low and SRAM bus zero.
    task automatic chk_quiet(input int k, input string tag);
        chk({tag, "_ctl"}, {27'd0, f_gnt[k], m_gnt[k], f_rvalid[k], m_rvalid[k], mem_en[k]}, 32'd0);
        chk({tag, "_bus"}, {12'd0, mem_w_en[k], mem_addr[k]}, 32'd0);
        chk({tag, "_wd"}, mem_wdata[k], 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; f_req[k] = 1'b0; f_addr[k] = 16'h0; m_req[k] = 1'b0;
            m_addr[k] = 16'h0; m_w_en[k] = 4'h0; m_wdata[k] = 32'h0;
        end

        // Reset held, then released with no requests.
        repeat (3) next_cyc();
        mid();
        for (int k = 0; k < 3; k++) begin
            chk_quiet(k, "rst");
            chk("rst_rdata", f_rdata[k] | m_rdata[k], 32'd0);
        end
        next_cyc();
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk_quiet(0, "idle");
            chk("idle_rdata", f_rdata[0] | m_rdata[0], 32'd0);
            next_cyc();
        end

        // Fetch read on LAT=1.
        f_req[0] = 1'b1; f_addr[0] = 16'h0010;
        mid();
        chk("f_gnt_T", f_gnt[0], 1'b1);
        chk("f_m_gnt_T", m_gnt[0], 1'b0);
        chk("f_mem_en_T", mem_en[0], 1'b1);
        chk("f_mem_addr_T", mem_addr[0], 16'h0010);
        chk("f_mem_w_en_T", mem_w_en[0], 4'h0);
        next_cyc(); f_req[0] = 1'b0; mid();
        chk("f_busy_T1", {f_gnt[0], mem_en[0], f_rvalid[0]}, 3'b000);
        next_cyc(); mid();
        chk("f_rvalid_T2", f_rvalid[0], 1'b1);
        chk("f_rdata_T2", f_rdata[0], 32'hDEAD_BEEF);
        next_cyc(); mid();
        chk("f_rvalid_T3", f_rvalid[0], 1'b0);
        chk("f_rdata_hold", f_rdata[0], 32'hDEAD_BEEF);

        // Store then load back-to-back.
        next_cyc();
        m_req[0] = 1'b1; m_addr[0] = 16'h0100; m_w_en[0] = 4'b1111; m_wdata[0] = 32'h1234_5678;
        mid();
        chk("st_gnt", m_gnt[0], 1'b1);
        chk("st_mem_w_en", mem_w_en[0], 4'b1111);
        chk("st_mem_addr", mem_addr[0], 16'h0100);
        chk("st_mem_wdata", mem_wdata[0], 32'h1234_5678);
        next_cyc(); m_w_en[0] = 4'b0000; m_wdata[0] = 32'h0; mid();
        chk("ld_gnt", m_gnt[0], 1'b1);
        chk("ld_mem_w_en", mem_w_en[0], 4'b0000);
        chk("st_no_rvalid", m_rvalid[0], 1'b0);
        next_cyc(); m_req[0] = 1'b0; mid();
        chk("ld_busy", {m_gnt[0], m_rvalid[0]}, 2'b00);
        next_cyc(); mid();
        chk("ld_rvalid", m_rvalid[0], 1'b1);
        chk("ld_rdata", m_rdata[0], 32'h1234_5678);
        chk("ld_f_rvalid", f_rvalid[0], 1'b0);

        // Priority and starvation guard: M writes contend with a waiting fetch.
        next_cyc();
        f_req[0] = 1'b1; f_addr[0] = 16'h0020;
        m_req[0] = 1'b1; m_addr[0] = 16'h0200; m_w_en[0] = 4'b0001; m_wdata[0] = 32'h0000_00AA;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("stv_m_gnt", m_gnt[0], 1'b1);
            chk("stv_f_gnt", f_gnt[0], 1'b0);
            chk("stv_cnt", 32'(g_dut[0].u_dut.r_starve_cnt), i);
            next_cyc();
        end
        mid();
        chk("stv_f_win", {f_gnt[0], m_gnt[0]}, 2'b10);
        chk("stv_f_addr", mem_addr[0], 16'h0020);
        chk("stv_f_w_en", mem_w_en[0], 4'h0);
        next_cyc(); f_req[0] = 1'b0; mid();
        chk("stv_cnt_clr", 32'(g_dut[0].u_dut.r_starve_cnt), 32'd0);
        chk("stv_busy_m", m_gnt[0], 1'b0);
        next_cyc(); mid();
        chk("stv_f_rvalid", f_rvalid[0], 1'b1);
        chk("stv_f_rdata", f_rdata[0], 32'h0BAD_F00D);
        chk("stv_m_overlap", m_gnt[0], 1'b1);
        next_cyc(); m_req[0] = 1'b0; m_w_en[0] = 4'h0;

        // Latency sweep on LAT=4 with a pending data read.
        f_req[1] = 1'b1; f_addr[1] = 16'h0010;
        mid();
        chk("l4_f_gnt", f_gnt[1], 1'b1);
        next_cyc();
        f_req[1] = 1'b0; m_req[1] = 1'b1; m_addr[1] = 16'h0020; m_w_en[1] = 4'h0;
        for (int i = 1; i <= 4; i++) begin
            mid();
            chk("l4_busy", {f_gnt[1], m_gnt[1], mem_en[1], f_rvalid[1]}, 4'b0000);
            next_cyc();
        end
        mid();
        chk("l4_f_rvalid", f_rvalid[1], 1'b1);
        chk("l4_f_rdata", f_rdata[1], 32'hDEAD_BEEF);
        chk("l4_m_gnt", m_gnt[1], 1'b1);
        chk("l4_m_addr", mem_addr[1], 16'h0020);
        next_cyc(); m_req[1] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            mid();
            chk("l4_m_wait", {m_rvalid[1], f_rvalid[1]}, 2'b00);
            next_cyc();
        end
        mid();
        chk("l4_m_rvalid", m_rvalid[1], 1'b1);
        chk("l4_m_rdata", m_rdata[1], 32'h0BAD_F00D);

        // Reset in the middle of a LAT=3 read.
        next_cyc();
        f_req[2] = 1'b1; f_addr[2] = 16'h0010;
        mid();
        chk("rmid_gnt", f_gnt[2], 1'b1);
        next_cyc(); f_req[2] = 1'b0; rst[2] = 1'b0; mid();
        chk("rmid_state", 32'(g_dut[2].u_dut.r_state), 32'd0);
        next_cyc(); next_cyc(); rst[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("rmid_no_rvalid", f_rvalid[2], 1'b0);
            chk("rmid_rdata", f_rdata[2], 32'd0);
            next_cyc();
        end
        f_req[2] = 1'b1; f_addr[2] = 16'h0020;
        mid();
        chk("rmid_regnt", f_gnt[2], 1'b1);
        next_cyc(); f_req[2] = 1'b0;
        next_cyc(); next_cyc(); mid();
        chk("rmid_pre_rvalid", f_rvalid[2], 1'b0);
        next_cyc(); mid();
        chk("rmid_rvalid", f_rvalid[2], 1'b1);
        chk("rmid_new_rdata", f_rdata[2], 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
